// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the sequential signed divider:
//   state_t    - FSM state encodings (2-bit)
//   clog2()    - bit width needed to count 0..n-1
//   minValue() - most negative W-bit two's-complement value, zero-extended to 64 bits
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FIXUP  = 2'd2
  } state_t;

  // Smallest v with 2**v >= n, with a floor of 1 so a counter always has at least one bit
  function automatic int clog2(input int n);
    int v;
    v = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << v) < n) v = v + 1;
    end
    return v;
  endfunction

  // Only bit w-1 is set; callers truncate the result to w bits
  function automatic logic [63:0] minValue(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div_if.sv
// div_if
// Start/valid handshake bundle between the arithmetic controller and the divider.
//   start      - request, honoured only while the divider is idle
//   a, b       - signed dividend / divisor (W bits)
//   busy       - divider is working
//   valid      - one-cycle pulse when q/r/dbz/ovf are updated
//   q, r       - signed quotient / remainder (W bits)
//   dbz, ovf   - divide-by-zero and MIN/-1 overflow flags for the current result
// master: controller side, slave: divider side.
interface div_if #(parameter int W = 4);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         valid;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dbz;
  logic         ovf;

  modport master (
    output start, a, b,
    input  busy, valid, q, r, dbz, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, valid, q, r, dbz, ovf
  );

endinterface

// File: rtl/div_step.sv
// div_step
// One restoring-division step, purely combinational.
//   i_rem     - current partial remainder (W+1 bits)
//   i_bit     - next dividend bit, MSB first
//   i_divisor - divisor magnitude (W bits, unsigned)
//   o_rem     - updated partial remainder
//   o_qBit    - quotient bit produced by this step
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W:0]   o_rem,
  output logic         o_qBit
);

  logic [W+1:0] w_trial;
  logic [W+1:0] w_diff;

  // The trial value is formed one bit wider than the remainder so the subtraction
  // borrow lands in the top bit; no borrow means trial >= divisor and the
  // difference is kept, otherwise the trial value is kept unchanged (restore).
  assign w_trial = {i_rem, i_bit};
  assign w_diff  = w_trial - {2'b00, i_divisor};
  assign o_qBit  = ~w_diff[W+1];
  assign o_rem   = o_qBit ? w_diff[W:0] : w_trial[W:0];

endmodule

// File: rtl/div_sequential.sv
// div_sequential
// Sequential signed restoring divider, one quotient bit per clock, paired with the
// shift-add multiplier (same start/valid handshake and operand width).
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset; aborts any division in flight
//   bus   - div_if slave: start/a/b in, busy/valid/q/r/dbz/ovf out
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// Result appears W+1 edges after the accepting edge for every operand pair.
// W must match the parameter of the connected div_if.
module div_sequential
  import div_pkg::*;
#(
  parameter int W = 4
) (
  input logic  clk,
  input logic  rst_n,
  div_if.slave bus
);

  localparam int           CW       = clog2(W);
  localparam logic [W-1:0] MIN_VAL  = W'(minValue(W));
  localparam logic [W-1:0] ALL_ONES = '1;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_dvd;
  logic [W:0]    r_rem;
  logic [W-1:0]  r_dvs;
  logic [W-1:0]  r_aCap;
  logic          r_signQ;
  logic          r_signR;
  logic          r_dbzI;
  logic          r_ovfI;
  logic          r_busy;
  logic          r_valid;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_r;
  logic          r_dbz;
  logic          r_ovf;

  logic [W-1:0]  w_aMag;
  logic [W-1:0]  w_bMag;
  logic [W:0]    w_stepRem;
  logic          w_qBit;
  logic [W-1:0]  w_qSigned;
  logic [W-1:0]  w_rSigned;

  // Magnitudes are taken as unsigned W-bit values; negating MIN wraps back to
  // MIN, whose unsigned reading 2**(W-1) is exactly |MIN|.
  assign w_aMag = bus.a[W-1] ? -bus.a : bus.a;
  assign w_bMag = bus.b[W-1] ? -bus.b : bus.b;

  // The final remainder is always smaller than |b|, so its low W bits carry it fully.
  assign w_qSigned = r_signQ ? -r_dvd : r_dvd;
  assign w_rSigned = r_signR ? -r_rem[W-1:0] : r_rem[W-1:0];

  div_step #(.W(W)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[W-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_stepRem),
    .o_qBit    (w_qBit)
  );

  // Control and datapath in one block. IDLE captures operands on start, DIVIDE
  // shifts the dividend out MSB-first while quotient bits fill its vacated LSBs,
  // and FIXUP applies signs or the special-case results and pulses valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_aCap  <= '0;
      r_signQ <= 1'b0;
      r_signR <= 1'b0;
      r_dbzI  <= 1'b0;
      r_ovfI  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (bus.start) begin
            r_dvd   <= w_aMag;
            r_dvs   <= w_bMag;
            r_aCap  <= bus.a;
            r_signQ <= bus.a[W-1] ^ bus.b[W-1];
            r_signR <= bus.a[W-1];
            r_dbzI  <= (bus.b == '0);
            r_ovfI  <= (bus.a == MIN_VAL) && (bus.b == ALL_ONES);
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_DIVIDE;
          end
        end

        ST_DIVIDE: begin
          r_rem <= w_stepRem;
          r_dvd <= {r_dvd[W-2:0], w_qBit};
          if (r_cnt == CW'(W - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_FIXUP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_FIXUP: begin
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
          r_state <= ST_IDLE;
          if (r_dbzI) begin
            r_q   <= ALL_ONES;
            r_r   <= r_aCap;
            r_dbz <= 1'b1;
            r_ovf <= 1'b0;
          end else if (r_ovfI) begin
            r_q   <= MIN_VAL;
            r_r   <= '0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b1;
          end else begin
            r_q   <= w_qSigned;
            r_r   <= w_rSigned;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.valid = r_valid;
  assign bus.q     = r_q;
  assign bus.r     = r_r;
  assign bus.dbz   = r_dbz;
  assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_div_sequential.sv
// tb_div_sequential
// Scoreboard bench for div_sequential at W=4. Stimulus pushes the hand-computed
// result for each accepted operation; a negedge monitor pops and compares on valid.
module tb_div_sequential;

  localparam int W = 4;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   validCount;
  exp_t sbQ[$];
  exp_t monExp;
  logic [3:0] b2bA[3];
  logic [3:0] b2bB[3];
  exp_t       b2bE[3];

  div_if #(.W(W)) bus();

  div_sequential #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the design locks up
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mkExp(input logic [3:0] q, input logic [3:0] r,
                                 input logic dbz, input logic ovf);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.ovf = ovf;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      validCount++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected valid", {7'b0, bus.valid}, 8'd0);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("q",   {4'b0, bus.q},   {4'b0, monExp.q});
        checkOutput("r",   {4'b0, bus.r},   {4'b0, monExp.r});
        checkOutput("dbz", {7'b0, bus.dbz}, {7'b0, monExp.dbz});
        checkOutput("ovf", {7'b0, bus.ovf}, {7'b0, monExp.ovf});
      end
    end
  end

  // Issue one operation from a negedge, scramble a/b after acceptance, optionally
  // poke start mid-divide, then wait (bounded) for valid and check latency/busy.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input exp_t e, input bit intrude);
    int k;
    int busyCnt;
    bit seen;
    k = 0;
    while (bus.busy === 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    sbQ.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    k       = 1;
    busyCnt = 0;
    seen    = 1'b0;
    while (!seen && k <= 20) begin
      if (bus.valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.busy === 1'b1) busyCnt++;
        if (intrude && k == 2) begin
          bus.start = 1'b1;
          bus.a     = 4'd1;
          bus.b     = 4'd1;
        end else if (intrude && k == 3) begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    checkOutput("latency", 8'(k), 8'(W + 2));
    checkOutput("busy cycles", 8'(busyCnt), 8'(W + 1));
    checkOutput("busy at valid", {7'b0, bus.busy}, 8'd0);
  endtask

  initial begin
    int k;
    int vc;
    checks     = 0;
    errors     = 0;
    validCount = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;

    b2bA[0] = 4'd3;    b2bB[0] = 4'd3;    b2bE[0] = mkExp(4'd1,    4'd0,    1'b0, 1'b0);
    b2bA[1] = -4'sd5;  b2bB[1] = 4'd2;    b2bE[1] = mkExp(-4'sd2,  -4'sd1,  1'b0, 1'b0);
    b2bA[2] = 4'd4;    b2bB[2] = -4'sd3;  b2bE[2] = mkExp(-4'sd1,  4'd1,    1'b0, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("reset q", {4'b0, bus.q}, 8'd0);
    checkOutput("reset r", {4'b0, bus.r}, 8'd0);
    checkOutput("reset flags", {4'b0, bus.busy, bus.valid, bus.dbz, bus.ovf}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] signed quotient/remainder cases");
    applyStimulus(4'd7,   4'd2,   mkExp(4'd3,   4'd1,   1'b0, 1'b0), 1'b0);
    applyStimulus(-4'sd7, 4'd2,   mkExp(4'b1101, 4'b1111, 1'b0, 1'b0), 1'b0);
    applyStimulus(4'd7,   -4'sd2, mkExp(4'b1101, 4'd1,  1'b0, 1'b0), 1'b0);
    applyStimulus(-4'sd8, 4'd3,   mkExp(4'b1110, 4'b1110, 1'b0, 1'b0), 1'b0);

    $display("[TB] overflow and divide-by-zero");
    applyStimulus(-4'sd8, -4'sd1, mkExp(4'b1000, 4'd0,  1'b0, 1'b1), 1'b0);
    applyStimulus(4'd6,   4'd3,   mkExp(4'd2,   4'd0,   1'b0, 1'b0), 1'b0);
    applyStimulus(4'd5,   4'd0,   mkExp(4'b1111, 4'd5,  1'b1, 1'b0), 1'b0);
    applyStimulus(-4'sd3, 4'd0,   mkExp(4'b1111, 4'b1101, 1'b1, 1'b0), 1'b0);

    $display("[TB] start while busy is ignored");
    @(negedge clk);
    vc = validCount;
    applyStimulus(4'd7, 4'd2, mkExp(4'd3, 4'd1, 1'b0, 1'b0), 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("single valid", 8'(validCount - vc), 8'd1);

    $display("[TB] start held high, back-to-back");
    for (int i = 0; i < 3; i++) begin
      bus.a     = b2bA[i];
      bus.b     = b2bB[i];
      bus.start = 1'b1;
      @(posedge clk);
      sbQ.push_back(b2bE[i]);
      @(negedge clk);
      k = 1;
      while (bus.valid !== 1'b1 && k <= 20) begin
        @(negedge clk);
        k++;
      end
      checkOutput("b2b period", 8'(k), 8'(W + 2));
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] asynchronous reset mid-divide");
    vc        = validCount;
    bus.a     = 4'd7;
    bus.b     = 4'd2;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort q", {4'b0, bus.q}, 8'd0);
    checkOutput("abort r", {4'b0, bus.r}, 8'd0);
    checkOutput("abort flags", {4'b0, bus.busy, bus.valid, bus.dbz, bus.ovf}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("no valid after abort", 8'(validCount - vc), 8'd0);
    applyStimulus(-4'sd6, 4'd4, mkExp(4'b1111, 4'b1110, 1'b0, 1'b0), 1'b0);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard drained", 8'(sbQ.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
